// File: rtl/viterbi_pkg.sv
// viterbi_pkg
//   Shared trellis definitions for the rate-1/2, K=3 (g0=111, g1=101) decoder.
//   State s = {b[n-1], b[n-2]}; the encoder register seen for input b is {b, s}.
//   Helpers: next_state(s,b), enc_out(s,b) -> {c0,c1}, pred_state(s',lsb).
//   Optional build macro used by the decoder files: VIT_RENORM_EN.
package viterbi_pkg;

  localparam int          K          = 3;
  localparam int          NUM_STATES = 4;
  localparam logic [2:0]  G0         = 3'b111;
  localparam logic [2:0]  G1         = 3'b101;

  typedef logic [1:0] state_t;

  // Successor of state s when input bit b is shifted in.
  function automatic state_t next_state(input state_t s, input logic b);
    return {b, s[1]};
  endfunction

  // Encoder output {c0,c1} for the transition leaving state s on input b.
  function automatic logic [1:0] enc_out(input state_t s, input logic b);
    logic [2:0] v_reg;
    v_reg = {b, s};
    return {^(v_reg & G0), ^(v_reg & G1)};
  endfunction

  // Predecessor of s' = {b, x} whose oldest bit is p_lsb: {x, p_lsb}.
  function automatic state_t pred_state(input state_t sp, input logic p_lsb);
    return {sp[0], p_lsb};
  endfunction

endpackage

// File: rtl/viterbi_acs_stage_bmu.sv
// viterbi_bmu
//   Branch metric unit (pipeline stage 1). Converts the signed soft pair to
//   offset binary and registers the four branch metrics with the frame flag.
//   Ports: CLK, RST (async, active-high), i_load (stage may advance),
//   i_valid/i_frame_start/i_r0/i_r1 (symbol), o_valid/o_frame_start,
//   o_bm00..o_bm11 (SW+1 bits, indexed by expected {c0,c1}).
//   Build macro VIT_RENORM_EN does not affect this file.
module viterbi_bmu #(
  parameter int SW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_load,
  input  logic          i_valid,
  input  logic          i_frame_start,
  input  logic [SW-1:0] i_r0,
  input  logic [SW-1:0] i_r1,
  output logic          o_valid,
  output logic          o_frame_start,
  output logic [SW:0]   o_bm00,
  output logic [SW:0]   o_bm01,
  output logic [SW:0]   o_bm10,
  output logic [SW:0]   o_bm11
);

  logic [SW-1:0] w_u0, w_u1;

  // Flipping the sign bit maps -2^(SW-1)..2^(SW-1)-1 onto 0..2^SW-1, so u is
  // the cost of an expected 0 and ~u (= 2^SW-1-u) the cost of an expected 1.
  assign w_u0 = i_r0 ^ {1'b1, {(SW-1){1'b0}}};
  assign w_u1 = i_r1 ^ {1'b1, {(SW-1){1'b0}}};

  // Stage-1 register: advances only when the next stage can take its contents.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      o_valid       <= 1'b0;
      o_frame_start <= 1'b0;
      o_bm00        <= '0;
      o_bm01        <= '0;
      o_bm10        <= '0;
      o_bm11        <= '0;
    end else if (i_load) begin
      o_valid       <= i_valid;
      o_frame_start <= i_valid & i_frame_start;
      if (i_valid) begin
        o_bm00 <= {1'b0,  w_u0} + {1'b0,  w_u1};
        o_bm01 <= {1'b0,  w_u0} + {1'b0, ~w_u1};
        o_bm10 <= {1'b0, ~w_u0} + {1'b0,  w_u1};
        o_bm11 <= {1'b0, ~w_u0} + {1'b0, ~w_u1};
      end
    end
  end

endmodule

// File: rtl/viterbi_acs_stage.sv
// viterbi_acs_stage
//   Two-stage add-compare-select for the 4-state K=3 decoder: stage 1 is the
//   branch metric unit, stage 2 updates the path metrics and emits one
//   decision bit per state plus the best state and its metric.
//   Ports: CLK, RST (async, active-high); in_valid/in_ready, frame_start,
//   r0/r1 (signed soft symbols); out_valid/out_ready, dec[3:0],
//   best_state[1:0], best_metric[MW-1:0].
//   Build macro VIT_RENORM_EN: defined -> subtract 2^(MW-1) from all metrics
//   once all reach it; undefined -> each metric saturates at 2^MW-1.
module viterbi_acs_stage
  import viterbi_pkg::*;
#(
  parameter int SW      = 8,
  parameter int MW      = 10,
  parameter int INIT_PM = 64
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          frame_start,
  input  logic [SW-1:0] r0,
  input  logic [SW-1:0] r1,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    dec,
  output logic [1:0]    best_state,
  output logic [MW-1:0] best_metric
);

  logic          w_stall;
  logic          w_s1_valid;
  logic          w_s1_frame;
  logic [SW:0]   w_bm      [NUM_STATES];
  logic [MW-1:0] r_pm      [NUM_STATES];
  logic [MW-1:0] w_pm_old  [NUM_STATES];
  logic [MW:0]   w_cand0   [NUM_STATES];
  logic [MW:0]   w_cand1   [NUM_STATES];
  logic [MW:0]   w_sel     [NUM_STATES];
  logic [MW-1:0] w_pm_new  [NUM_STATES];
  logic [3:0]    w_dec;
  logic [1:0]    w_best_state;
  logic [MW-1:0] w_best_metric;
`ifdef VIT_RENORM_EN
  logic          w_all_hi;
  logic [MW:0]   w_adj     [NUM_STATES];
`endif

  assign w_stall  = out_valid & ~out_ready;
  // Stage 1 may still fill a bubble while the output is stalled.
  assign in_ready = ~(w_s1_valid & w_stall);

  viterbi_bmu #(.SW(SW)) u_bmu (
    .CLK           (CLK),
    .RST           (RST),
    .i_load        (in_ready),
    .i_valid       (in_valid),
    .i_frame_start (frame_start),
    .i_r0          (r0),
    .i_r1          (r1),
    .o_valid       (w_s1_valid),
    .o_frame_start (w_s1_frame),
    .o_bm00        (w_bm[0]),
    .o_bm01        (w_bm[1]),
    .o_bm10        (w_bm[2]),
    .o_bm11        (w_bm[3])
  );

  // Add-compare-select, overflow handling and minimum search for one symbol.
  always_comb begin
    for (int i = 0; i < NUM_STATES; i++) begin
      w_pm_old[i] = w_s1_frame ? ((i == 0) ? '0 : MW'(INIT_PM)) : r_pm[i];
    end
    for (int sp = 0; sp < NUM_STATES; sp++) begin
      w_cand0[sp] = {1'b0, w_pm_old[pred_state(2'(sp), 1'b0)]}
                  + (MW+1)'(w_bm[enc_out(pred_state(2'(sp), 1'b0), sp[1])]);
      w_cand1[sp] = {1'b0, w_pm_old[pred_state(2'(sp), 1'b1)]}
                  + (MW+1)'(w_bm[enc_out(pred_state(2'(sp), 1'b1), sp[1])]);
      // Strictly-less keeps p0 on a tie.
      w_dec[sp]   = (w_cand1[sp] < w_cand0[sp]);
      w_sel[sp]   = w_dec[sp] ? w_cand1[sp] : w_cand0[sp];
    end
`ifdef VIT_RENORM_EN
    w_all_hi = 1'b1;
    for (int sp = 0; sp < NUM_STATES; sp++) begin
      w_all_hi = w_all_hi & (|w_sel[sp][MW:MW-1]);
    end
    for (int sp = 0; sp < NUM_STATES; sp++) begin
      w_adj[sp]    = w_all_hi ? (w_sel[sp] - (MW+1)'(2**(MW-1))) : w_sel[sp];
      // Guard only reachable with a metric spread wider than 2^(MW-1).
      w_pm_new[sp] = w_adj[sp][MW] ? '1 : w_adj[sp][MW-1:0];
    end
`else
    for (int sp = 0; sp < NUM_STATES; sp++) begin
      w_pm_new[sp] = w_sel[sp][MW] ? '1 : w_sel[sp][MW-1:0];
    end
`endif
    w_best_state  = 2'd0;
    w_best_metric = w_pm_new[0];
    for (int sp = 1; sp < NUM_STATES; sp++) begin
      w_best_state  = (w_pm_new[sp] < w_best_metric) ? 2'(sp) : w_best_state;
      w_best_metric = (w_pm_new[sp] < w_best_metric) ? w_pm_new[sp] : w_best_metric;
    end
  end

  // Stage-2 register: path metrics and the decision word, frozen while stalled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        r_pm[i] <= (i == 0) ? '0 : MW'(INIT_PM);
      end
      out_valid   <= 1'b0;
      dec         <= 4'b0000;
      best_state  <= 2'd0;
      best_metric <= '0;
    end else if (!w_stall) begin
      out_valid <= w_s1_valid;
      if (w_s1_valid) begin
        for (int i = 0; i < NUM_STATES; i++) begin
          r_pm[i] <= w_pm_new[i];
        end
        dec         <= w_dec;
        best_state  <= w_best_state;
        best_metric <= w_best_metric;
      end
    end
  end

endmodule

// File: tb/tb_viterbi_acs_stage.sv
// tb_viterbi_acs_stage
//   Scoreboard bench: each accepted symbol pushes its expected decision word
//   (hand-computed where given, otherwise from an independent trellis model);
//   a negedge monitor pops and compares every consumed output.
module tb_viterbi_acs_stage;

  logic       CLK;
  logic       RST;
  logic       in_valid;
  logic       in_ready;
  logic       frame_start;
  logic [7:0] r0;
  logic [7:0] r1;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] dec;
  logic [1:0] best_state;
  logic [9:0] best_metric;

  typedef struct packed {
    logic [3:0] dec;
    logic [1:0] bs;
    logic [9:0] bm;
  } exp_t;

  exp_t sb_q[$];
  int   m_pm[4];
  int   checks = 0;
  int   errors = 0;
  bit   t5_done;

  viterbi_acs_stage #(.SW(8), .MW(10), .INIT_PM(64)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .frame_start (frame_start),
    .r0          (r0),
    .r1          (r1),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dec         (dec),
    .best_state  (best_state),
    .best_metric (best_metric)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic int cost(input int u, input int bit_v);
    return (bit_v != 0) ? (255 - u) : u;
  endfunction

  task automatic model_reset();
    m_pm[0] = 0; m_pm[1] = 64; m_pm[2] = 64; m_pm[3] = 64;
  endtask

  // Independent trellis model: s'={b,x}, predecessors {x,0},{x,1}.
  task automatic model_step(input int a, input int b, input bit fs, output exp_t e);
    int u0, u1, bb, x, p, c0, c1, best;
    int old[4];
    int nw[4];
    int cand[2];
    logic [3:0] d;
    u0 = a + 128;
    u1 = b + 128;
    for (int i = 0; i < 4; i++) old[i] = fs ? ((i == 0) ? 0 : 64) : m_pm[i];
    for (int sp = 0; sp < 4; sp++) begin
      bb = sp / 2;
      x  = sp % 2;
      for (int k = 0; k < 2; k++) begin
        p  = 2 * x + k;
        c0 = bb ^ (p / 2) ^ (p % 2);
        c1 = bb ^ (p % 2);
        cand[k] = old[p] + cost(u0, c0) + cost(u1, c1);
      end
      d[sp]  = (cand[1] < cand[0]);
      nw[sp] = d[sp] ? cand[1] : cand[0];
    end
`ifdef VIT_RENORM_EN
    if (nw[0] >= 512 && nw[1] >= 512 && nw[2] >= 512 && nw[3] >= 512)
      for (int i = 0; i < 4; i++) nw[i] = nw[i] - 512;
`endif
    for (int i = 0; i < 4; i++) if (nw[i] > 1023) nw[i] = 1023;
    best = 0;
    for (int i = 1; i < 4; i++) if (nw[i] < nw[best]) best = i;
    for (int i = 0; i < 4; i++) m_pm[i] = nw[i];
    e.dec = d;
    e.bs  = 2'(best);
    e.bm  = 10'(nw[best]);
  endtask

  // Drive one symbol from posedge+1; push expectation on acceptance.
  task automatic send(input int a, input int b, input bit fs, input bit hand,
                      input logic [3:0] hd, input logic [1:0] hs, input logic [9:0] hm);
    exp_t e;
    bit   ok;
    in_valid    = 1'b1;
    frame_start = fs;
    r0          = 8'(a);
    r1          = 8'(b);
    ok          = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge CLK);
      if (in_ready) begin
        model_step(a, b, fs, e);
        if (hand) begin
          e.dec = hd; e.bs = hs; e.bm = hm;
        end
        sb_q.push_back(e);
        ok = 1'b1;
      end
      @(posedge CLK);
      #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 50 cycles");
    end
    in_valid    = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && sb_q.size() != 0; t++) @(negedge CLK);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outputs missing, required 0", sb_q.size());
    end
    @(posedge CLK);
    #1;
  endtask

  // Monitor: pop on every consumed output; outputs must hold while stalled.
  exp_t m_snap;
  bit   m_prev_stall = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      m_prev_stall = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: dec=%b bs=%0d bm=%0d with empty scoreboard",
                   dec, best_state, best_metric);
        end else begin
          e = sb_q.pop_front();
          if (dec !== e.dec || best_state !== e.bs || best_metric !== e.bm) begin
            errors++;
            $display("FAIL decision_word: got dec=%b bs=%0d bm=%0d, required dec=%b bs=%0d bm=%0d",
                     dec, best_state, best_metric, e.dec, e.bs, e.bm);
          end
        end
      end
      if (out_valid && !out_ready) begin
        if (m_prev_stall) begin
          checks++;
          if ({dec, best_state, best_metric} !== m_snap) begin
            errors++;
            $display("FAIL stall_hold: got %h, required %h",
                     {dec, best_state, best_metric}, m_snap);
          end
        end
        m_snap       = {dec, best_state, best_metric};
        m_prev_stall = 1'b1;
      end else begin
        m_prev_stall = 1'b0;
      end
    end
  end

  task automatic check1(input string name, input logic [15:0] got, input logic [15:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; frame_start = 1'b0;
    r0 = 8'd0; r1 = 8'd0; out_ready = 1'b1; t5_done = 1'b0;
    model_reset();
    #12;
    check1("reset_out_valid",   16'(out_valid),   16'd0);
    check1("reset_dec",         16'(dec),         16'd0);
    check1("reset_best_state",  16'(best_state),  16'd0);
    check1("reset_best_metric", 16'(best_metric), 16'd0);
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;
    @(posedge CLK);
    #1;
    check1("reset_in_ready", 16'(in_ready), 16'd1);

    // T1: strong 0s from {0,64,64,64}: s'=2 prefers p1=1 (bm00, 64 < 510),
    // s'=1 and s'=3 tie at 319 -> dec=0100, pm={0,319,64,319}.
    send(-128, -128, 1'b1, 1'b1, 4'b0100, 2'd0, 10'd0);
    // T2: strong 1s -> pm={319,319,0,319}, state 0 takes p1, dec=0001.
    send(127, 127, 1'b0, 1'b1, 4'b0001, 2'd2, 10'd0);
    drain();

    // T4: r=0 on a new frame: s'=1 and s'=3 tie (319) -> p0; pm={256,319,254,319}.
    send(0, 0, 1'b1, 1'b1, 4'b0000, 2'd2, 10'd254);
    send(50, -30, 1'b0, 1'b0, 4'b0, 2'd0, 10'd0);
    send(-100, 90, 1'b0, 1'b0, 4'b0, 2'd0, 10'd0);
    send(5, 5, 1'b0, 1'b0, 4'b0, 2'd0, 10'd0);
    drain();

    // T3: stall for several cycles while the source keeps offering symbols.
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
               1'b0, 1'b0, 4'b0, 2'd0, 10'd0);
      end
      begin
        repeat (3) @(posedge CLK);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        check1("stall_in_ready",  16'(in_ready),  16'd0);
        check1("stall_out_valid", 16'(out_valid), 16'd1);
        @(posedge CLK);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // T5: long random stream with random back-pressure to exercise overflow.
    fork
      begin
        for (int i = 0; i < 2000; i++)
          send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
               (i == 0), 1'b0, 4'b0, 2'd0, 10'd0);
        t5_done = 1'b1;
      end
      begin
        while (!t5_done) begin
          @(posedge CLK);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // T6: reset in the middle of a burst.
    send(-128, -128, 1'b1, 1'b0, 4'b0, 2'd0, 10'd0);
    send(40, -20, 1'b0, 1'b0, 4'b0, 2'd0, 10'd0);
    send(-70, 60, 1'b0, 1'b0, 4'b0, 2'd0, 10'd0);
    in_valid = 1'b1; r0 = 8'd17; r1 = 8'd99;
    RST = 1'b1;
    #1;
    check1("midreset_out_valid",   16'(out_valid),   16'd0);
    check1("midreset_dec",         16'(dec),         16'd0);
    check1("midreset_best_metric", 16'(best_metric), 16'd0);
    in_valid = 1'b0;
    sb_q.delete();
    model_reset();
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;
    @(posedge CLK);
    #1;
    check1("midreset_in_ready", 16'(in_ready), 16'd1);
    // Without frame_start the reset metrics {0,64,64,64} must be in use.
    send(-128, -128, 1'b0, 1'b1, 4'b0100, 2'd0, 10'd0);
    send(127, 127, 1'b0, 1'b1, 4'b0001, 2'd2, 10'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
